fdiv_64: RTL and testbench

Iterative double-precision (IEEE-754 binary64 format) floating-point divider, the inverse companion to the pipelined multiplier in the FPU datapath. It accepts one operand pair on a start pulse and computes a/b with a restoring radix-2 mantissa divider, one quotient bit per clock. After a fixed latency it presents a registered 64-bit result with a one-cycle done strobe and exception flags. Intended for the core's execute stage alongside the multiplier, sharing its simplified number format: no denormals, truncation rounding.

---
 rtl/fdiv_64.sv | 142 ++++++++++++++
 tb/tb_fdiv_64.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_64.sv
// fdiv_64 - iterative binary64 divider (restoring radix-2, one quotient bit
// per clock). Simplified number format: exponent field 0 means zero (no
// denormals), exponent 2047 is an ordinary exponent, truncation rounding.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   start - request, only sampled while idle
//   a, b  - dividend / divisor {sign, exp[10:0], frac[51:0]}, sampled with start
//   out   - registered quotient, held until the next done
//   done  - one-cycle strobe, out and flags valid
//   busy  - high from the cycle after accept through the done cycle
//   dz    - divide-by-zero flag (held with out)
//   ovf   - exponent overflow flag (held with out)
//   unf   - exponent underflow flag (held with out)
module fdiv_64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] out,
   output logic        done,
   output logic        busy,
   output logic        dz,
   output logic        ovf,
   output logic        unf
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DIV  = 2'd1;
   localparam logic [1:0] NORM = 2'd2;

   logic [1:0]  state;
   logic        sign;
   logic        a_zero, b_zero;
   logic [10:0] ea, eb;
   logic [52:0] mb;
   logic [53:0] rem;
   logic [53:0] quo;
   logic [5:0]  cnt;

   // Partial remainder always stays below 2*mb, so 54 bits never overflow
   // and the shifted value drops a guaranteed-zero top bit.
   logic [53:0] diff;
   logic        ge;
   assign diff = rem - {1'b0, mb};
   assign ge   = rem >= {1'b0, mb};

   // Exponent is evaluated in 13-bit signed so both over- and underflow
   // are visible before truncating to the 11-bit field.
   logic signed [12:0] e_base, e_n;
   logic        [51:0] frac;
   always_comb begin
      e_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023;
      e_n    = e_base;
      frac   = quo[52:1];
      if (!quo[53]) begin
         e_n  = e_base - 13'sd1;
         frac = quo[51:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sign   <= 1'b0;
         a_zero <= 1'b0;
         b_zero <= 1'b0;
         ea     <= '0;
         eb     <= '0;
         mb     <= '0;
         rem    <= '0;
         quo    <= '0;
         cnt    <= '0;
         out    <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
         dz     <= 1'b0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  sign   <= a[63] ^ b[63];
                  ea     <= a[62:52];
                  eb     <= b[62:52];
                  a_zero <= (a[62:52] == 11'd0);
                  b_zero <= (b[62:52] == 11'd0);
                  mb     <= {1'b1, b[51:0]};
                  rem    <= {2'b01, a[51:0]};
                  quo    <= '0;
                  cnt    <= 6'd53;
                  state  <= DIV;
               end
            end
            DIV: begin
               busy <= 1'b1;
               if (ge) begin
                  quo <= {quo[52:0], 1'b1};
                  rem <= {diff[52:0], 1'b0};
               end else begin
                  quo <= {quo[52:0], 1'b0};
                  rem <= {rem[52:0], 1'b0};
               end
               cnt <= cnt - 6'd1;
               if (cnt == 6'd0) state <= NORM;
            end
            NORM: begin
               busy <= 1'b1;
               done <= 1'b1;
               dz   <= 1'b0;
               ovf  <= 1'b0;
               unf  <= 1'b0;
               if (b_zero && a_zero) begin
                  out <= 64'h7FF8000000000000;
                  dz  <= 1'b1;
               end else if (b_zero) begin
                  out <= {sign, 11'h7FF, 52'd0};
                  dz  <= 1'b1;
               end else if (a_zero) begin
                  out <= {sign, 63'd0};
               end else if (e_n >= 13'sd2047) begin
                  out <= {sign, 11'h7FF, 52'd0};
                  ovf <= 1'b1;
               end else if (e_n <= 13'sd0) begin
                  out <= {sign, 63'd0};
                  unf <= 1'b1;
               end else begin
                  out <= {sign, e_n[10:0], frac};
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fdiv_64.sv
// Self-checking bench for fdiv_64: arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal results.
module tb_fdiv_64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] a = '0, b = '0;
   logic [63:0] out;
   logic        done, busy, dz, ovf, unf;

   fdiv_64 dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                .out(out), .done(done), .busy(busy), .dz(dz), .ovf(ovf), .unf(unf));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int          due;
      logic [63:0] out;
      logic        dz, ovf, unf;
   } exp_t;
   exp_t q[$];
   int next_ok = 0;
   logic [63:0] held_out = '0;
   logic        held_dz = 0, held_ovf = 0, held_unf = 0;

   // Reference: full-precision integer division, then normalise/classify.
   function automatic exp_t model(input logic [63:0] x, input logic [63:0] y);
      exp_t r;
      logic [127:0] num, den, qt;
      logic         sgn;
      int           e;
      logic [51:0]  fr;
      sgn = x[63] ^ y[63];
      num = {75'd0, 1'b1, x[51:0]} << 53;
      den = {75'd0, 1'b1, y[51:0]};
      qt  = num / den;
      e   = int'(x[62:52]) - int'(y[62:52]) + 1023;
      if (qt[53]) fr = qt[52:1];
      else begin fr = qt[51:0]; e = e - 1; end
      r.due = 0; r.dz = 0; r.ovf = 0; r.unf = 0;
      if (x[62:52] == 0 && y[62:52] == 0) begin r.out = 64'h7FF8000000000000; r.dz = 1; end
      else if (y[62:52] == 0) begin r.out = {sgn, 11'h7FF, 52'd0}; r.dz = 1; end
      else if (x[62:52] == 0) r.out = {sgn, 63'd0};
      else if (e >= 2047) begin r.out = {sgn, 11'h7FF, 52'd0}; r.ovf = 1; end
      else if (e <= 0) begin r.out = {sgn, 63'd0}; r.unf = 1; end
      else r.out = {sgn, e[10:0], fr};
      return r;
   endfunction

   // Model of acceptance: one op in flight, next accept 56 edges later.
   always @(posedge clk) begin
      exp_t r;
      cyc = cyc + 1;
      if (rst) begin
         q.delete();
         next_ok = cyc + 1;
         held_out = '0; held_dz = 0; held_ovf = 0; held_unf = 0;
      end else if (start && cyc >= next_ok) begin
         r = model(a, b);
         r.due = cyc + 55;
         q.push_back(r);
         next_ok = cyc + 56;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      logic eb;
      if (cyc > 0) begin
         eb = (q.size() > 0) && (cyc >= q[0].due - 54) && (cyc <= q[0].due);
         chk("busy", {63'd0, busy}, {63'd0, eb});
         if (q.size() > 0 && q[0].due == cyc) begin
            held_out = q[0].out; held_dz = q[0].dz; held_ovf = q[0].ovf; held_unf = q[0].unf;
            void'(q.pop_front());
            chk("done", {63'd0, done}, 64'd1);
         end else begin
            chk("done", {63'd0, done}, 64'd0);
         end
         chk("out", out, held_out);
         chk("flags", {61'd0, dz, ovf, unf}, {61'd0, held_dz, held_ovf, held_unf});
      end
   end

   int acc_cyc;

   task automatic go(input logic [63:0] x, input logic [63:0] y);
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      acc_cyc = cyc;
      start = 1'b0;
      a = $urandom(); b = {$urandom(), $urandom()};
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin lat = cyc - acc_cyc; break; end
      end
      if (lat < 0) begin
         errors++; checks++;
         $display("FAIL timeout waiting for done");
      end
   endtask

   task automatic run(input string name, input logic [63:0] x, input logic [63:0] y,
                      input logic [63:0] eo, input logic [2:0] ef);
      int lat;
      go(x, y);
      wait_done(lat);
      chk({name, "_lat"}, 64'(lat), 64'd55);
      chk({name, "_out"}, out, eo);
      chk({name, "_flg"}, {61'd0, dz, ovf, unf}, {61'd0, ef});
   endtask

   initial begin
      int lat, bcnt;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_out", out, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);

      // 6/2 with busy cycle count
      go(64'h4018000000000000, 64'h4000000000000000);
      bcnt = 0; lat = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin lat = cyc - acc_cyc; break; end
      end
      chk("six_lat", 64'(lat), 64'd55);
      chk("six_busy", 64'(bcnt), 64'd55);
      chk("six_out", out, 64'h4008000000000000);

      run("third", 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 3'b000);
      run("neg",   64'hBFF8000000000000, 64'h3FE0000000000000, 64'hC008000000000000, 3'b000);
      run("dz",    64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 3'b100);
      run("zz",    64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 3'b100);
      run("nz",    64'h8000000000000000, 64'h4000000000000000, 64'h8000000000000000, 3'b000);
      run("ovf",   64'h7FE0000000000000, 64'h0010000000000000, 64'h7FF0000000000000, 3'b010);
      run("unf",   64'h0010000000000000, 64'h7FE0000000000000, 64'h0000000000000000, 3'b001);
      run("clr",   64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 3'b000);

      // starts while busy are ignored
      go(64'h4014000000000000, 64'h4000000000000000);       // 5/2 = 2.5
      repeat (8) @(negedge clk);
      a = 64'h4000000000000000; b = 64'h3FF0000000000000; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (19) @(negedge clk);
      a = 64'h3FF0000000000000; b = 64'h3FF0000000000000; start = 1'b1;
      @(negedge clk); start = 1'b0;
      a = '0; b = '0;
      wait_done(lat);
      chk("ign_lat", 64'(lat), 64'd55);
      chk("ign_out", out, 64'h4004000000000000);

      // start held during the done cycle: state is IDLE, so it is accepted
      go(64'h4022000000000000, 64'h4008000000000000);       // 9/3 = 3
      wait_done(lat);
      chk("bb_out0", out, 64'h4008000000000000);
      a = 64'h4000000000000000; b = 64'h3FF0000000000000; start = 1'b1;   // 2/1
      @(posedge clk); #1;
      acc_cyc = cyc; start = 1'b0;
      wait_done(lat);
      chk("bb_lat", 64'(lat), 64'd55);
      chk("bb_out1", out, 64'h4000000000000000);

      // reset mid-operation
      go(64'h4018000000000000, 64'h4008000000000000);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_busy", {63'd0, busy}, 64'd0);
      chk("mid_out", out, 64'd0);
      bcnt = 0;
      repeat (60) begin @(negedge clk); if (done) bcnt++; end
      chk("mid_nodone", 64'(bcnt), 64'd0);
      run("after", 64'h4018000000000000, 64'h4008000000000000, 64'h4000000000000000, 3'b000);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
